// File: rtl/roi_io_pkg.sv
// Shared types and helpers for the ROI serial I/O harness.
// The optional parity bit is enabled by defining ROI_IO_PARITY_EN.
package roi_io_pkg;

    localparam int SETTLE_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SETTLE,
        CAPTURE,
        SHIFT_OUT
    } roi_io_state_t;

    // Bits needed for a counter that must be able to hold the value n itself.
    function automatic int cnt_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/roi_io_shreg.sv
// Left-shifting register with parallel load; a load takes priority over a shift.
module roi_io_shreg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         shift_en,
    input  logic         sin,
    input  logic         load_en,
    input  logic [W-1:0] pdata,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (load_en) begin
            q <= pdata;
        end else if (shift_en) begin
            q <= {q[W-2:0], sin};
        end
    end

endmodule

// File: rtl/roi_io_shifter.sv
// Serial-in / serial-out harness around a wide ROI: gather, load, settle, capture, stream.
// Define ROI_IO_PARITY_EN to append an even-parity bit to each output stream.
module roi_io_shifter
    import roi_io_pkg::*;
#(
    parameter int DIN_N      = 256,
    parameter int DOUT_N     = 256,
    parameter int SETTLE_CYC = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              di,
    input  logic              di_valid,
    input  logic              stb,
    output logic              busy,
    output logic              in_full,
    output logic              do_ser,
    output logic              do_valid,
    output logic [DIN_N-1:0]  roi_din,
    input  logic [DOUT_N-1:0] roi_dout
);

    localparam int IN_CW  = cnt_width(DIN_N);
    localparam int OUT_CW = cnt_width(DOUT_N);
`ifdef ROI_IO_PARITY_EN
    localparam int LAST_BIT = DOUT_N;
`else
    localparam int LAST_BIT = DOUT_N - 1;
`endif
    localparam logic [OUT_CW-1:0]   LAST_IDX    = OUT_CW'(LAST_BIT);
    localparam logic [IN_CW-1:0]    IN_FULL_CNT = IN_CW'(DIN_N);
    localparam logic [SETTLE_W-1:0] SETTLE_INIT = SETTLE_W'(SETTLE_CYC - 1);

    roi_io_state_t       state;
    logic [DIN_N-1:0]    din_shr;
    logic [DOUT_N-1:0]   dout_shr;
    logic [IN_CW-1:0]    in_cnt;
    logic [OUT_CW-1:0]   out_cnt;
    logic [SETTLE_W-1:0] settle_cnt;
`ifdef ROI_IO_PARITY_EN
    logic                parity_bit;
`endif

    roi_io_shreg #(.W(DIN_N)) u_in_shr (
        .clk      (clk),
        .rst_n    (rst_n),
        .shift_en (di_valid),
        .sin      (di),
        .load_en  (1'b0),
        .pdata    ({DIN_N{1'b0}}),
        .q        (din_shr)
    );

    roi_io_shreg #(.W(DOUT_N)) u_out_shr (
        .clk      (clk),
        .rst_n    (rst_n),
        .shift_en (state == SHIFT_OUT),
        .sin      (1'b0),
        .load_en  (state == CAPTURE),
        .pdata    (roi_dout),
        .q        (dout_shr)
    );

    // The load cycle restarts the count, but a bit arriving in that same cycle still counts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_cnt <= '0;
        end else if (state == LOAD) begin
            in_cnt <= di_valid ? IN_CW'(1) : '0;
        end else if (di_valid && (in_cnt != IN_FULL_CNT)) begin
            in_cnt <= in_cnt + 1'b1;
        end
    end

    assign in_full = (in_cnt == IN_FULL_CNT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            roi_din    <= '0;
            settle_cnt <= '0;
            out_cnt    <= '0;
            busy       <= 1'b0;
            do_valid   <= 1'b0;
`ifdef ROI_IO_PARITY_EN
            parity_bit <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (stb) begin
                        state <= LOAD;
                        busy  <= 1'b1;
                    end
                end
                LOAD: begin
                    roi_din    <= din_shr;
                    settle_cnt <= SETTLE_INIT;
                    state      <= SETTLE;
                end
                SETTLE: begin
                    if (settle_cnt == '0) begin
                        state <= CAPTURE;
                    end else begin
                        settle_cnt <= settle_cnt - 1'b1;
                    end
                end
                CAPTURE: begin
                    out_cnt  <= '0;
                    do_valid <= 1'b1;
`ifdef ROI_IO_PARITY_EN
                    parity_bit <= ^roi_dout;
`endif
                    state    <= SHIFT_OUT;
                end
                SHIFT_OUT: begin
                    if (out_cnt == LAST_IDX) begin
                        state    <= IDLE;
                        busy     <= 1'b0;
                        do_valid <= 1'b0;
                    end else begin
                        out_cnt <= out_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef ROI_IO_PARITY_EN
    assign do_ser = do_valid &
                    ((out_cnt == OUT_CW'(DOUT_N)) ? parity_bit : dout_shr[DOUT_N-1]);
`else
    assign do_ser = do_valid & dout_shr[DOUT_N-1];
`endif

endmodule

// File: tb/tb_roi_io_shifter.sv
// Directed bench for roi_io_shifter (DIN_N=DOUT_N=8, SETTLE_CYC=2, roi_dout = ~roi_din).
// Expectations adapt when ROI_IO_PARITY_EN is defined.
module tb_roi_io_shifter;

    localparam int DIN_N      = 8;
    localparam int DOUT_N     = 8;
    localparam int SETTLE_CYC = 2;
`ifdef ROI_IO_PARITY_EN
    localparam int STREAM_N = 9;
`else
    localparam int STREAM_N = 8;
`endif
    localparam int FIRST_CYC = 3 + SETTLE_CYC;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              di;
    logic              di_valid;
    logic              stb;
    logic              busy;
    logic              in_full;
    logic              do_ser;
    logic              do_valid;
    logic [DIN_N-1:0]  roi_din;
    logic [DOUT_N-1:0] roi_dout;
    logic              use_fixed;
    logic [DOUT_N-1:0] fixed_dout;

    int          vectors;
    int          miscompares;
    logic [15:0] seen_bits;
    int          seen_n;
    int          first_cyc;
    int          busy_falls;
    int          shift_busy;
    logic        prev_busy;
    logic [7:0]  din_at2;
    logic [3:0]  incnt_at2;

    assign roi_dout = use_fixed ? fixed_dout : ~roi_din;

    always #5 clk = ~clk;

    roi_io_shifter #(
        .DIN_N      (DIN_N),
        .DOUT_N     (DOUT_N),
        .SETTLE_CYC (SETTLE_CYC)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .di       (di),
        .di_valid (di_valid),
        .stb      (stb),
        .busy     (busy),
        .in_full  (in_full),
        .do_ser   (do_ser),
        .do_valid (do_valid),
        .roi_din  (roi_din),
        .roi_dout (roi_dout)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // MSB of the n-bit field of v goes in first.
    task automatic shiftBits(input logic [7:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            di       = v[i];
            di_valid = 1'b1;
            tick();
        end
        di_valid = 1'b0;
        di       = 1'b0;
    endtask

    // Pulse stb, then watch 30 cycles; optional extra stb pulses and one di_valid pulse.
    task automatic applyStimulus(input int stb_a, input int stb_b, input int dv_at);
        seen_bits  = '0;
        seen_n     = 0;
        first_cyc  = 0;
        busy_falls = 0;
        shift_busy = 0;
        prev_busy  = 1'b1;
        stb = 1'b1;
        tick();
        stb = 1'b0;
        for (int c = 1; c <= 30; c++) begin
            if (do_valid) begin
                if (seen_n == 0) first_cyc = c;
                seen_bits = {seen_bits[14:0], do_ser};
                seen_n++;
                if (busy) shift_busy++;
            end
            if (prev_busy && !busy) busy_falls++;
            prev_busy = busy;
            if (c == 2) begin
                din_at2   = roi_din;
                incnt_at2 = dut.in_cnt;
            end
            stb      = (c == stb_a) || (c == stb_b);
            di_valid = (c == dv_at);
            di       = (c == dv_at);
            tick();
        end
        stb      = 1'b0;
        di_valid = 1'b0;
        di       = 1'b0;
    endtask

    task automatic checkStream(input string tag, input logic [7:0] data);
        logic [31:0] exp;
`ifdef ROI_IO_PARITY_EN
        exp = {23'b0, data, ^data};
`else
        exp = {24'b0, data};
`endif
        checkOutput({tag, "_len"}, 32'(seen_n), 32'(STREAM_N));
        checkOutput({tag, "_first"}, 32'(first_cyc), 32'(FIRST_CYC));
        checkOutput({tag, "_bits"}, 32'(seen_bits) & ((32'd1 << STREAM_N) - 1), exp);
        checkOutput({tag, "_busyfall"}, 32'(busy_falls), 32'd1);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        di          = 1'b0;
        di_valid    = 1'b0;
        stb         = 1'b0;
        use_fixed   = 1'b0;
        fixed_dout  = 8'h00;
        #12;
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_in_full", 32'(in_full), 32'd0);
        checkOutput("rst_do_valid", 32'(do_valid), 32'd0);
        checkOutput("rst_do_ser", 32'(do_ser), 32'd0);
        checkOutput("rst_roi_din", 32'(roi_din), 32'h00);
        rst_n = 1'b1;
        tick();

        $display("[TB] basic load and stream");
        shiftBits(8'hB2, 8);
        applyStimulus(0, 0, 0);
        checkOutput("t1_roi_din", 32'(din_at2), 32'hB2);
        checkStream("t1", 8'h4D);
        checkOutput("t1_idle_busy", 32'(busy), 32'd0);

        $display("[TB] in_full and overflow");
        shiftBits(8'h52, 7);
        checkOutput("t2_not_full", 32'(in_full), 32'd0);
        shiftBits(8'h01, 1);
        checkOutput("t2_full", 32'(in_full), 32'd1);
        checkOutput("t2_shr_a5", 32'(dut.din_shr), 32'hA5);
        shiftBits(8'h06, 3);
        checkOutput("t2_still_full", 32'(in_full), 32'd1);
        checkOutput("t2_shr_2e", 32'(dut.din_shr), 32'h2E);

        $display("[TB] stb ignored while busy");
        applyStimulus(3, 8, 0);
        checkOutput("t3_roi_din", 32'(din_at2), 32'h2E);
        checkStream("t3", 8'hD1);

        $display("[TB] di_valid during load");
        applyStimulus(0, 0, 1);
        checkOutput("t4_roi_din", 32'(din_at2), 32'h2E);
        checkOutput("t4_in_cnt", 32'(incnt_at2), 32'd1);
        checkOutput("t4_shr_5d", 32'(dut.din_shr), 32'h5D);
        checkOutput("t4_in_full", 32'(in_full), 32'd0);
        checkStream("t4", 8'hD1);

        $display("[TB] async reset mid-stream");
        shiftBits(8'hB2, 8);
        stb = 1'b1;
        tick();
        stb = 1'b0;
        for (int c = 1; c < 8; c++) tick();
        checkOutput("t5_pre_valid", 32'(do_valid), 32'd1);
        checkOutput("t5_pre_ser", 32'(do_ser), 32'd0);
        rst_n = 1'b0;
        #1;
        checkOutput("t5_valid", 32'(do_valid), 32'd0);
        checkOutput("t5_busy", 32'(busy), 32'd0);
        checkOutput("t5_roi_din", 32'(roi_din), 32'h00);
        checkOutput("t5_in_full", 32'(in_full), 32'd0);
        tick();
        tick();
        checkOutput("t5_valid_held", 32'(do_valid), 32'd0);
        rst_n = 1'b1;
        tick();
        shiftBits(8'hB2, 8);
        applyStimulus(0, 0, 0);
        checkOutput("t5_roi_din2", 32'(din_at2), 32'hB2);
        checkStream("t5", 8'h4D);

        $display("[TB] fixed roi_dout 4D");
        use_fixed  = 1'b1;
        fixed_dout = 8'h4D;
        applyStimulus(0, 0, 0);
`ifdef ROI_IO_PARITY_EN
        checkOutput("t6_bits", 32'(seen_bits[8:0]), {23'b0, 8'h4D, 1'b0});
`else
        checkOutput("t6_bits", 32'(seen_bits[7:0]), 32'h4D);
`endif
        checkOutput("t6_len", 32'(seen_n), 32'(STREAM_N));
        checkOutput("t6_busy_shift", 32'(shift_busy), 32'(STREAM_N));
        checkOutput("t6_busyfall", 32'(busy_falls), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
